// File: rtl/synth_pitch_pkg.sv
// Shared types and helpers for the pitch-glide slice of the synth engine.
// Slot numbering is voice-major: all oscillators of a voice are adjacent.
package synth_pitch_pkg;

    localparam int DEFAULT_PW = 24;

    // 2'b11 is deliberately not a member; it falls through to "off".
    typedef enum logic [1:0] {
        GLIDE_OFF = 2'b00,
        GLIDE_LIN = 2'b01,
        GLIDE_EXP = 2'b10
    } glide_mode_e;

    function automatic int unsigned slot_idx(input int unsigned vx,
                                             input int unsigned ox,
                                             input int unsigned n_osc);
        return vx * n_osc + ox;
    endfunction

endpackage

// File: rtl/glide_step.sv
// One portamento step: moves cur toward target by the snap, linear or
// exponential rule, never past target and never wrapping.
module glide_step
    import synth_pitch_pkg::*;
#(
    parameter int PW        = DEFAULT_PW,
    parameter int LIN_SHIFT = 4
) (
    input  logic [PW-1:0] cur,
    input  logic [PW-1:0] target,
    input  logic [1:0]    mode,
    input  logic [7:0]    rate,
    input  logic          snap,
    output logic [PW-1:0] next
);

    logic signed [PW:0] diff;
    logic signed [PW:0] neg_diff;
    logic               up;
    logic [PW-1:0]      mag;
    logic [8:0]         lin_base;
    logic [PW-1:0]      lin_step;
    logic [PW-1:0]      exp_step;
    logic [4:0]         exp_shift;

    always_comb begin
        diff      = $signed({1'b0, target}) - $signed({1'b0, cur});
        neg_diff  = -diff;
        up        = ~diff[PW];
        mag       = up ? diff[PW-1:0] : neg_diff[PW-1:0];
        lin_base  = 9'd256 - {1'b0, rate};
        lin_step  = PW'(lin_base) << LIN_SHIFT;
        exp_shift = {1'b0, rate[7:4]} + 5'd1;
        exp_step  = mag >> exp_shift;
    end

    // A step is only taken when it lands strictly short of target, so the
    // result stays between cur and target without any overflow handling.
    always_comb begin
        next = target;
        if (!snap) begin
            case (mode)
                GLIDE_LIN: begin
                    if (mag > lin_step)
                        next = up ? (cur + lin_step) : (cur - lin_step);
                end
                GLIDE_EXP: begin
                    if (exp_step != '0)
                        next = up ? (cur + exp_step) : (cur - exp_step);
                end
                default: next = target;
            endcase
        end
    end

endmodule

// File: rtl/pitch_glide.sv
// Per-slot portamento engine: holds the current pitch of every voice x
// oscillator slot and moves it toward the streamed target on each visit.
module pitch_glide
    import synth_pitch_pkg::*;
#(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int PW        = DEFAULT_PW,
    parameter int LIN_SHIFT = 4
) (
    input  logic               sCLK_XVXOSC,
    input  logic               reset_reg,
    // slot_valid qualifies slot_vx/slot_ox/target_pitch for exactly one
    // cycle; there is no ready, a slot is accepted every cycle it is valid.
    input  logic               slot_valid,
    input  logic [V_WIDTH-1:0] slot_vx,
    input  logic [O_WIDTH-1:0] slot_ox,
    input  logic [PW-1:0]      target_pitch,
    input  logic               note_trig,
    input  logic [V_WIDTH-1:0] trig_vx,
    input  logic               legato,
    input  logic [1:0]         glide_mode,
    input  logic [7:0]         glide_rate,
    output logic               out_valid,
    output logic [V_WIDTH-1:0] out_vx,
    output logic [O_WIDTH-1:0] out_ox,
    output logic [PW-1:0]      glide_pitch,
    output logic [VOICES-1:0]  glide_active
);

    localparam int NSLOT = VOICES * V_OSC;
    localparam int SW    = V_WIDTH + O_WIDTH;

    logic [PW-1:0]     cur_q [NSLOT];
    logic [NSLOT-1:0]  snap_pend_q;
    logic [NSLOT-1:0]  busy_q;

    logic               s1_valid;
    logic [V_WIDTH-1:0] s1_vx;
    logic [O_WIDTH-1:0] s1_ox;
    logic [SW-1:0]      s1_idx;
    logic [PW-1:0]      s1_target;
    logic [PW-1:0]      s1_cur;
    logic [1:0]         s1_mode;
    logic [7:0]         s1_rate;

    logic [SW-1:0]      in_idx;
    logic [PW-1:0]      step_next;

    assign in_idx = SW'(slot_idx(32'(slot_vx), 32'(slot_ox), V_OSC));

    glide_step #(
        .PW        (PW),
        .LIN_SHIFT (LIN_SHIFT)
    ) u_step (
        .cur    (s1_cur),
        .target (s1_target),
        .mode   (s1_mode),
        .rate   (s1_rate),
        .snap   (snap_pend_q[s1_idx]),
        .next   (step_next)
    );

    // Stage 1: capture the slot and read its pitch, taking the value being
    // written this edge when the same slot is back-to-back.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            s1_valid  <= 1'b0;
            s1_vx     <= '0;
            s1_ox     <= '0;
            s1_idx    <= '0;
            s1_target <= '0;
            s1_cur    <= '0;
            s1_mode   <= '0;
            s1_rate   <= '0;
        end else begin
            s1_valid <= slot_valid;
            if (slot_valid) begin
                s1_vx     <= slot_vx;
                s1_ox     <= slot_ox;
                s1_idx    <= in_idx;
                s1_target <= target_pitch;
                s1_mode   <= glide_mode;
                s1_rate   <= glide_rate;
                s1_cur    <= (s1_valid && (s1_idx == in_idx)) ? step_next
                                                              : cur_q[in_idx];
            end
        end
    end

    // Stage 2: commit the stepped pitch and the per-slot busy flag.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            for (int s = 0; s < NSLOT; s++) cur_q[s] <= '0;
            busy_q <= '0;
        end else if (s1_valid) begin
            cur_q[s1_idx]  <= step_next;
            busy_q[s1_idx] <= (step_next != s1_target);
        end
    end

    // A note trigger landing on the same edge as a visit's clear wins, so
    // that slot snaps again on its following visit.
    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            snap_pend_q <= '1;
        end else begin
            if (s1_valid)
                snap_pend_q[s1_idx] <= 1'b0;
            if (note_trig && !legato) begin
                for (int unsigned o = 0; o < V_OSC; o++)
                    snap_pend_q[SW'(slot_idx(32'(trig_vx), o, V_OSC))] <= 1'b1;
            end
        end
    end

    always_ff @(posedge sCLK_XVXOSC or posedge reset_reg) begin
        if (reset_reg) begin
            out_valid   <= 1'b0;
            out_vx      <= '0;
            out_ox      <= '0;
            glide_pitch <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_vx      <= s1_vx;
                out_ox      <= s1_ox;
                glide_pitch <= step_next;
            end
        end
    end

    // busy_q is already registered, so this tracks the stage-2 write edge.
    always_comb begin
        glide_active = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            for (int unsigned o = 0; o < V_OSC; o++) begin
                if (busy_q[SW'(slot_idx(v, o, V_OSC))])
                    glide_active[v] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pitch_glide.sv
// Bench for pitch_glide: directed scenarios plus randomized traffic, checked
// against an arithmetic per-slot portamento model with a two-cycle expect queue.
module tb_pitch_glide;

    localparam int VOICES    = 8;
    localparam int V_OSC     = 4;
    localparam int V_WIDTH   = 3;
    localparam int O_WIDTH   = 2;
    localparam int PW        = 24;
    localparam int LIN_SHIFT = 4;
    localparam int NSLOT     = VOICES * V_OSC;
    localparam int EW        = 1 + V_WIDTH + O_WIDTH + PW + VOICES;

    logic               clk = 1'b0;
    logic               rst;
    logic               slot_valid;
    logic [V_WIDTH-1:0] slot_vx;
    logic [O_WIDTH-1:0] slot_ox;
    logic [PW-1:0]      target_pitch;
    logic               note_trig;
    logic [V_WIDTH-1:0] trig_vx;
    logic               legato;
    logic [1:0]         glide_mode;
    logic [7:0]         glide_rate;
    logic               out_valid;
    logic [V_WIDTH-1:0] out_vx;
    logic [O_WIDTH-1:0] out_ox;
    logic [PW-1:0]      glide_pitch;
    logic [VOICES-1:0]  glide_active;

    always #5 clk = ~clk;

    pitch_glide #(
        .VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
        .PW(PW), .LIN_SHIFT(LIN_SHIFT)
    ) dut (
        .sCLK_XVXOSC  (clk),
        .reset_reg    (rst),
        .slot_valid   (slot_valid),
        .slot_vx      (slot_vx),
        .slot_ox      (slot_ox),
        .target_pitch (target_pitch),
        .note_trig    (note_trig),
        .trig_vx      (trig_vx),
        .legato       (legato),
        .glide_mode   (glide_mode),
        .glide_rate   (glide_rate),
        .out_valid    (out_valid),
        .out_vx       (out_vx),
        .out_ox       (out_ox),
        .glide_pitch  (glide_pitch),
        .glide_active (glide_active)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_cur  [NSLOT];
    bit               m_snap [NSLOT];
    bit               m_busy [NSLOT];
    logic [EW-1:0]    exp_q[$];
    int               d_mode;
    int               d_rate;

    task automatic model_reset();
        for (int s = 0; s < NSLOT; s++) begin
            m_cur[s]  = 0;
            m_snap[s] = 1'b1;
            m_busy[s] = 1'b0;
        end
    endtask

    function automatic int model_next(input int cur, input int tgt, input int mode,
                                      input int rate, input bit snap);
        int mag;
        int step;
        if (snap || mode == 0 || mode == 3) return tgt;
        mag = (tgt > cur) ? tgt - cur : cur - tgt;
        if (mode == 1) begin
            step = (256 - rate) * (1 << LIN_SHIFT);
            if (mag <= step) return tgt;
        end else begin
            step = mag / (1 << (rate / 16 + 1));
            if (step == 0) return tgt;
        end
        return (tgt > cur) ? cur + step : cur - step;
    endfunction

    function automatic logic [VOICES-1:0] model_active();
        logic [VOICES-1:0] a;
        a = '0;
        for (int v = 0; v < VOICES; v++)
            for (int o = 0; o < V_OSC; o++)
                if (m_busy[v * V_OSC + o]) a[v] = 1'b1;
        return a;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_val("out_valid", 64'(out_valid), 64'(e[EW-1]));
            if (e[EW-1]) begin
                check_val("out_vx", 64'(out_vx), 64'(e[VOICES+PW+O_WIDTH +: V_WIDTH]));
                check_val("out_ox", 64'(out_ox), 64'(e[VOICES+PW +: O_WIDTH]));
                check_val("glide_pitch", 64'(glide_pitch), 64'(e[VOICES +: PW]));
            end
            check_val("glide_active", 64'(glide_active), 64'(e[VOICES-1:0]));
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_cycle(input bit v, input int vx, input int ox, input int tgt,
                             input bit trig, input int tvx, input bit leg);
        logic [EW-1:0] e;
        int s;
        int nx;
        @(posedge clk);
        #1;
        check_outputs();
        slot_valid   = v;
        slot_vx      = V_WIDTH'(vx);
        slot_ox      = O_WIDTH'(ox);
        target_pitch = PW'(tgt);
        note_trig    = trig;
        trig_vx      = V_WIDTH'(tvx);
        legato       = leg;
        glide_mode   = 2'(d_mode);
        glide_rate   = 8'(d_rate);
        if (trig && !leg)
            for (int o = 0; o < V_OSC; o++) m_snap[tvx * V_OSC + o] = 1'b1;
        e = '0;
        if (v) begin
            s = vx * V_OSC + ox;
            nx = model_next(m_cur[s], tgt, d_mode, d_rate, m_snap[s]);
            m_cur[s]  = nx;
            m_snap[s] = 1'b0;
            m_busy[s] = (nx != tgt);
            e = {1'b1, V_WIDTH'(vx), O_WIDTH'(ox), PW'(nx), VOICES'(0)};
        end
        e[VOICES-1:0] = model_active();
        exp_q.push_back(e);
    endtask

    task automatic visit(input int vx, input int ox, input int tgt);
        run_cycle(1'b1, vx, ox, tgt, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic trig(input int tvx, input bit leg);
        run_cycle(1'b0, 0, 0, 0, 1'b1, tvx, leg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tgt_of [NSLOT];

    initial begin
        rst = 1'b1;
        slot_valid = 1'b0; slot_vx = '0; slot_ox = '0; target_pitch = '0;
        note_trig = 1'b0; trig_vx = '0; legato = 1'b0; glide_mode = '0; glide_rate = '0;
        d_mode = 0; d_rate = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_vx", 64'(out_vx), 64'(0));
        check_val("rst_out_ox", 64'(out_ox), 64'(0));
        check_val("rst_glide_pitch", 64'(glide_pitch), 64'(0));
        check_val("rst_glide_active", 64'(glide_active), 64'(0));
        rst = 1'b0;

        // first visit after reset snaps, two-cycle latency
        d_mode = 1; d_rate = 0;
        visit(0, 0, 24'h010000);
        idle(2);
        check_val("t1_first_valid", 64'(out_valid), 64'(1));
        check_val("t1_first_pitch", 64'(glide_pitch), 64'(24'h010000));

        // linear glide 0x1000 -> 0x2000, step 0x100
        d_mode = 0;
        visit(2, 1, 24'h001000);
        d_mode = 1; d_rate = 240;
        for (int i = 0; i < 16; i++) visit(2, 1, 24'h002000);
        check_val("t2_mid_pitch", 64'(glide_pitch), 64'(24'h001E00));
        check_val("t2_mid_active", 64'(glide_active[2]), 64'(1));
        idle(2);
        check_val("t2_end_pitch", 64'(glide_pitch), 64'(24'h002000));
        check_val("t2_end_active", 64'(glide_active[2]), 64'(0));

        // exponential decay 0x8000 -> 0
        d_mode = 0;
        visit(1, 0, 24'h008000);
        d_mode = 2; d_rate = 0;
        for (int i = 0; i < 17; i++) visit(1, 0, 0);
        idle(2);
        check_val("t3_end_pitch", 64'(glide_pitch), 64'(0));

        // note_trig on voice 3: legato 0 snaps, legato 1 keeps gliding
        d_mode = 0;
        for (int o = 0; o < V_OSC; o++) visit(3, o, 0);
        d_mode = 1; d_rate = 0;
        for (int k = 0; k < 2; k++)
            for (int o = 0; o < V_OSC; o++) visit(3, o, 24'h100000);
        trig(3, 1'b0);
        for (int o = 0; o < V_OSC; o++) visit(3, o, 24'h100000);
        idle(2);
        check_val("t4_snap_pitch", 64'(glide_pitch), 64'(24'h100000));
        check_val("t4_snap_active", 64'(glide_active[3]), 64'(0));
        for (int o = 0; o < V_OSC; o++) visit(3, o, 0);
        trig(3, 1'b1);
        for (int o = 0; o < V_OSC; o++) visit(3, o, 0);
        idle(2);
        check_val("t4_legato_pitch", 64'(glide_pitch), 64'(24'h0FE000));
        check_val("t4_legato_active", 64'(glide_active[3]), 64'(1));

        // back-to-back visits of one slot exercise forwarding
        d_mode = 0;
        visit(5, 2, 0);
        d_mode = 1; d_rate = 240;
        visit(5, 2, 24'h001000);
        visit(5, 2, 24'h001000);
        idle(1);
        check_val("t5_fwd_first", 64'(glide_pitch), 64'(24'h000100));
        idle(1);
        check_val("t5_fwd_second", 64'(glide_pitch), 64'(24'h000200));

        // reset with a slot in stage 1
        visit(6, 3, 24'h001234);
        @(posedge clk);
        #2;
        rst = 1'b1;
        slot_valid = 1'b0;
        #1;
        check_val("t6_rst_valid", 64'(out_valid), 64'(0));
        check_val("t6_rst_pitch", 64'(glide_pitch), 64'(0));
        check_val("t6_rst_active", 64'(glide_active), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_val("t6_no_ghost", 64'(out_valid), 64'(0));
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        d_mode = 1; d_rate = 255;
        visit(6, 3, 24'h005555);
        idle(2);
        check_val("t6_post_snap", 64'(glide_pitch), 64'(24'h005555));

        // randomized traffic
        for (int s = 0; s < NSLOT; s++) tgt_of[s] = int'($urandom_range(0, 24'hFFFFFF));
        for (int c = 0; c < 3000; c++) begin
            int vx, ox, s, r;
            bit v, tr;
            vx = int'($urandom_range(0, VOICES - 1));
            ox = int'($urandom_range(0, V_OSC - 1));
            s  = vx * V_OSC + ox;
            v  = ($urandom_range(0, 9) < 7);
            tr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 19) == 0) d_mode = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) d_rate = int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0: tgt_of[s] = 0;
                    1: tgt_of[s] = 24'hFFFFFF;
                    2: tgt_of[s] = int'($urandom_range(0, 16'hFFFF));
                    default: tgt_of[s] = int'($urandom_range(0, 24'hFFFFFF));
                endcase
            end
            run_cycle(v, vx, ox, tgt_of[s], tr, int'($urandom_range(0, VOICES - 1)),
                      bit'($urandom_range(0, 1)));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
